// File: rtl/pdm_capture_if.sv
// Capture-side bundle: control in, PDM line, and the dbuf write/read port.
// No backpressure; dbuf accepts one access per clk.
interface pdm_capture_if;
    logic        start;
    logic        pdm_data;
    logic [15:0] rd_addr;
    logic        pdm_clk;
    logic [31:0] buf_din;
    logic [15:0] buf_didx;
    logic        buf_rw;
    logic        busy;
    logic        done;
    logic [15:0] word_cnt;

    modport master (
        input  start, pdm_data, rd_addr,
        output pdm_clk, buf_din, buf_didx, buf_rw, busy, done, word_cnt
    );

    modport slave (
        output start, pdm_data, rd_addr,
        input  pdm_clk, buf_din, buf_didx, buf_rw, busy, done, word_cnt
    );
endinterface

// File: rtl/pdm_capture.sv
// PDM mic capture: divides clk into pdm_clk, packs 32 samples MSB-first, writes DEPTH words into dbuf.
// One word every 64*CLK_DIV clks, all outputs registered; no backpressure, dbuf must take every write.
module pdm_capture #(
    parameter int CLK_DIV = 50,
    parameter int DEPTH   = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    pdm_capture_if.master bus
);

    localparam int                 DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0]        DEPTH_W  = 16'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e             state_q,    state_d;
    logic [DIV_W-1:0]   div_cnt_q,  div_cnt_d;
    logic [4:0]         bit_cnt_q,  bit_cnt_d;
    logic [15:0]        word_cnt_q, word_cnt_d;
    logic               pdm_clk_q,  pdm_clk_d;
    // Only the 31 oldest samples are kept; the 32nd goes straight into buf_din.
    logic [30:0]        shreg_q,    shreg_d;
    logic [31:0]        buf_din_q,  buf_din_d;
    logic [15:0]        buf_didx_q, buf_didx_d;
    logic               buf_rw_q,   buf_rw_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [31:0]        shreg_nxt;

    assign shreg_nxt = {shreg_q, bus.pdm_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            pdm_clk_q  <= 1'b0;
            shreg_q    <= '0;
            buf_din_q  <= '0;
            buf_didx_q <= '0;
            buf_rw_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            pdm_clk_q  <= pdm_clk_d;
            shreg_q    <= shreg_d;
            buf_din_q  <= buf_din_d;
            buf_didx_q <= buf_didx_d;
            buf_rw_q   <= buf_rw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        pdm_clk_d  = pdm_clk_q;
        shreg_d    = shreg_q;
        buf_din_d  = buf_din_q;
        buf_didx_d = buf_didx_q;
        buf_rw_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                pdm_clk_d  = 1'b0;
                buf_didx_d = bus.rd_addr;
                if (bus.start) begin
                    state_d    = S_CAPTURE;
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end
            S_CAPTURE: begin
                // The last word's write pulse is out; finish on the following edge.
                if (buf_rw_q && (word_cnt_q == DEPTH_W)) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pdm_clk_d = 1'b0;
                    div_cnt_d = '0;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    pdm_clk_d = ~pdm_clk_q;
                    if (pdm_clk_q) begin
                        shreg_d = shreg_nxt[30:0];
                        if (bit_cnt_q == 5'd31) begin
                            bit_cnt_d  = '0;
                            buf_din_d  = shreg_nxt;
                            buf_didx_d = word_cnt_q;
                            buf_rw_d   = 1'b1;
                            word_cnt_d = word_cnt_q + 16'd1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.pdm_clk  = pdm_clk_q;
    assign bus.buf_din  = buf_din_q;
    assign bus.buf_didx = buf_didx_q;
    assign bus.buf_rw   = buf_rw_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.word_cnt = word_cnt_q;

endmodule

// File: tb/tb_pdm_capture.sv
// Bench for pdm_capture: mic model + write scoreboard, dbuf model for readback, divider timing.
module tb_pdm_capture;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pdm_capture_if ifc2 ();
    pdm_capture_if ifc3 ();

    pdm_capture #(.CLK_DIV(2), .DEPTH(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));
    pdm_capture #(.CLK_DIV(3), .DEPTH(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(ifc3));

    typedef struct {
        logic [15:0] addr;
        logic [31:0] dat;
    } exp_t;

    typedef struct {
        logic [15:0] rd;
        logic [15:0] exp_didx;
        logic [31:0] exp_di;
    } rb_t;

    exp_t        exp_q[$];
    rb_t         rb_tbl[4];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          entry_cyc = 0;
    int          last_wr_cyc = 0;
    int          mic_mode = 0;
    int          mic_nb = 0;
    logic [15:0] mic_addr = '0;
    logic [31:0] mic_sh = '0;
    logic        mic_alt = 1'b1;
    logic [31:0] preset [4] = '{32'h12345678, 32'hDEADBEEF, 32'hC0FFEE01, 32'h80000001};
    logic [31:0] mem [4];
    logic [31:0] di_q = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // dbuf stand-in: registered read, write data passes through on a write cycle.
    always @(posedge clk) begin
        if (ifc2.buf_rw) mem[ifc2.buf_didx[1:0]] <= ifc2.buf_din;
        di_q <= ifc2.buf_rw ? ifc2.buf_din : mem[ifc2.buf_didx[1:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Microphone: presents a new bit after each pdm_clk rise, records the words it should produce.
    task automatic mic_model();
        logic b;
        forever begin
            @(posedge ifc2.pdm_clk);
            #1;
            case (mic_mode)
                0:       b = 1'b1;
                1:       begin b = mic_alt; mic_alt = ~mic_alt; end
                default: b = preset[mic_addr[1:0]][31 - mic_nb];
            endcase
            ifc2.pdm_data = b;
            mic_sh = {mic_sh[30:0], b};
            mic_nb++;
            if (mic_nb == 32) begin
                exp_q.push_back('{addr: mic_addr, dat: mic_sh});
                mic_addr = mic_addr + 16'd1;
                mic_nb = 0;
            end
        end
    endtask

    task automatic monitor();
        logic rw_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ifc2.buf_rw) begin
                chk("rw_single_cycle", 32'(rw_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("write_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_din", ifc2.buf_din, e.dat);
                    chk("write_didx", 32'(ifc2.buf_didx), 32'(e.addr));
                    chk("write_spacing", 32'(cyc - last_wr_cyc), 32'd128);
                    last_wr_cyc = cyc;
                end
            end
            rw_prev = rst_n & ifc2.buf_rw;
        end
    endtask

    task automatic do_start2(input bit fresh);
        if (fresh) begin
            exp_q.delete();
            mic_nb = 0; mic_addr = '0; mic_alt = 1'b1; mic_sh = '0;
        end
        @(negedge clk) ifc2.start = 1'b1;
        @(negedge clk) ifc2.start = 1'b0;
        if (fresh) begin
            entry_cyc = cyc;
            last_wr_cyc = cyc;
        end
    endtask

    task automatic wait_done2(input int budget);
        int n = 0;
        while (!ifc2.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 32'(ifc2.done), 32'd1);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_pdm_clk"},  32'(ifc2.pdm_clk),  32'd0);
        chk({p, "_buf_rw"},   32'(ifc2.buf_rw),   32'd0);
        chk({p, "_busy"},     32'(ifc2.busy),     32'd0);
        chk({p, "_done"},     32'(ifc2.done),     32'd0);
        chk({p, "_word_cnt"}, 32'(ifc2.word_cnt), 32'd0);
        chk({p, "_buf_didx"}, 32'(ifc2.buf_didx), 32'd0);
        chk({p, "_buf_din"},  ifc2.buf_din,       32'd0);
    endtask

    task automatic chk_done_state(input string p);
        int hi = 0;
        chk({p, "_busy"},     32'(ifc2.busy),     32'd0);
        chk({p, "_word_cnt"}, 32'(ifc2.word_cnt), 32'd4);
        repeat (30) begin
            @(negedge clk);
            if (ifc2.pdm_clk || ifc2.buf_rw) hi++;
        end
        chk({p, "_quiet"}, 32'(hi), 32'd0);
        chk({p, "_done_held"}, 32'(ifc2.done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, ph, len;
        logic prev;

        rb_tbl[0] = '{rd: 16'd2, exp_didx: 16'd2, exp_di: 32'hC0FFEE01};
        rb_tbl[1] = '{rd: 16'd0, exp_didx: 16'd0, exp_di: 32'h12345678};
        rb_tbl[2] = '{rd: 16'd3, exp_didx: 16'd3, exp_di: 32'h80000001};
        rb_tbl[3] = '{rd: 16'd1, exp_didx: 16'd1, exp_di: 32'hDEADBEEF};

        ifc2.start = 1'b0; ifc2.pdm_data = 1'b0; ifc2.rd_addr = '0;
        ifc3.start = 1'b0; ifc3.pdm_data = 1'b0; ifc3.rd_addr = '0;
        fork
            mic_model();
            monitor();
        join_none

        #1;
        chk_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifc2.pdm_clk || ifc3.pdm_clk) hi++;
        end
        chk("idle_no_pdm_clk", 32'(hi), 32'd0);

        // Alternating bits: first word and its exact timing.
        mic_mode = 1;
        do_start2(1'b1);
        chk("start_busy", 32'(ifc2.busy), 32'd1);
        n = 0;
        while (!ifc2.buf_rw && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("alt_first_din", ifc2.buf_din, 32'hAAAAAAAA);
        chk("alt_first_didx", 32'(ifc2.buf_didx), 32'd0);
        chk("alt_first_latency", 32'(cyc - entry_cyc), 32'd128);
        wait_done2(1000);
        chk_done_state("alt_done");

        // Constant ones; restart from DONE, stray start mid-capture.
        mic_mode = 0;
        do_start2(1'b1);
        chk("restart_done", 32'(ifc2.done), 32'd0);
        chk("restart_word_cnt", 32'(ifc2.word_cnt), 32'd0);
        repeat (200) @(negedge clk);
        do_start2(1'b0);
        chk("midstart_busy", 32'(ifc2.busy), 32'd1);
        chk("midstart_word_cnt", 32'(ifc2.word_cnt), 32'd1);
        wait_done2(1000);
        chk_done_state("ones_done");

        // Distinct words, then read them back out of order.
        mic_mode = 2;
        do_start2(1'b1);
        wait_done2(1000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) ifc2.rd_addr = rb_tbl[i].rd;
            @(negedge clk);
            chk("rb_didx", 32'(ifc2.buf_didx), 32'(rb_tbl[i].exp_didx));
            chk("rb_rw", 32'(ifc2.buf_rw), 32'd0);
            @(negedge clk);
            chk("rb_di", di_q, rb_tbl[i].exp_di);
        end

        // Asynchronous reset in the middle of a run.
        mic_mode = 0;
        do_start2(1'b1);
        repeat (300) @(negedge clk);
        chk("prereset_word_cnt", 32'(ifc2.word_cnt), 32'd2);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_start2(1'b1);
        wait_done2(1000);
        chk("after_reset_word_cnt", 32'(ifc2.word_cnt), 32'd4);

        // Divider with CLK_DIV=3: every phase exactly 3 clks.
        @(negedge clk) ifc3.start = 1'b1;
        @(negedge clk) ifc3.start = 1'b0;
        prev = 1'b0; len = 1; ph = 0; n = 0;
        while (ph < 40 && n < 400) begin
            @(negedge clk);
            n++;
            if (ifc3.pdm_clk === prev) begin
                len++;
            end else begin
                chk("div3_phase_len", 32'(len), 32'd3);
                prev = ifc3.pdm_clk;
                len = 1;
                ph++;
            end
        end
        chk("div3_phase_count", 32'(ph), 32'd40);
        n = 0;
        while (!ifc3.done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("div3_done", 32'(ifc3.done), 32'd1);
        hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (ifc3.pdm_clk) hi++;
        end
        chk("div3_done_no_pdm_clk", 32'(hi), 32'd0);
        chk("div3_word_cnt", 32'(ifc3.word_cnt), 32'd4);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
